// File: rtl/dram_cmd_sequencer.sv
// Command sequencer between the ORAM DRAM port and the DDR3 MIG user interface.
// Write commands are released only once their data beat has already reached
// the MIG (tracked by r_wr_ahead); read commands wait for a free slot in the
// downstream read path buffer (tracked by r_credits). One command in flight.
module dram_cmd_sequencer #(
  parameter int DDRAWidth   = 28,
  parameter int DDRCWidth   = 3,
  parameter int DDRDWidth   = 512,
  parameter int DDRMWidth   = 64,
  parameter int WDBuffering = 8,
  parameter int MaxWrAhead  = 4,
  parameter int ReadCredits = 64
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [DDRAWidth-1:0] InAddress,
  input  logic [DDRCWidth-1:0] InCommand,
  input  logic                 InCommandValid,
  output logic                 InCommandReady,
  input  logic [DDRDWidth-1:0] InWriteData,
  input  logic [DDRMWidth-1:0] InWriteMask,
  input  logic                 InWriteDataValid,
  output logic                 InWriteDataReady,
  input  logic                 ReadDrain,
  output logic [DDRAWidth-1:0] DRAMAddress,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic [DDRMWidth-1:0] DRAMWriteMask,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  output logic                 Error
);

  localparam int PtrW   = $clog2(WDBuffering);
  localparam int AheadW = $clog2(MaxWrAhead + 1);
  localparam int CredW  = $clog2(ReadCredits + 1);
  localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0);
  localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DDRAWidth-1:0]   r_addr;
  logic [DDRCWidth-1:0]   r_cmd;
  logic                   r_cmd_valid;
  logic                   r_in_rdy;
  logic                   r_error;
  logic [AheadW-1:0]      r_wr_ahead;
  logic [AheadW-1:0]      w_wr_ahead_nxt;
  logic [CredW-1:0]       r_credits;
  logic [CredW-1:0]       w_credits_nxt;

  // Write-data FIFO storage; the extra pointer bit separates full from empty.
  logic [DDRMWidth+DDRDWidth-1:0] r_mem [WDBuffering];
  logic [PtrW:0]                  r_wr_ptr;
  logic [PtrW:0]                  r_rd_ptr;
  logic [DDRMWidth+DDRDWidth-1:0] w_head;

  logic w_full, w_empty, w_push, w_pop;
  logic w_in_xfer, w_legal, w_cmd_xfer, w_wr_issue, w_rd_issue, w_credit_ovf;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                        (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_head       = r_mem[r_rd_ptr[PtrW-1:0]];

  assign InWriteDataReady   = !w_full;
  assign DRAMWriteDataValid = !w_empty && (r_wr_ahead < AheadW'(MaxWrAhead));
  assign DRAMWriteData      = w_head[DDRDWidth-1:0];
  assign DRAMWriteMask      = w_head[DDRMWidth+DDRDWidth-1:DDRDWidth];

  assign w_push       = InWriteDataValid && !w_full;
  assign w_pop        = DRAMWriteDataValid && DRAMWriteDataReady;
  assign w_in_xfer    = InCommandValid && r_in_rdy;
  assign w_legal      = (InCommand == CmdWrite) || (InCommand == CmdRead);
  assign w_cmd_xfer   = r_cmd_valid && DRAMCommandReady;
  assign w_wr_issue   = w_cmd_xfer && (r_cmd == CmdWrite);
  assign w_rd_issue   = w_cmd_xfer && (r_cmd == CmdRead);
  assign w_credit_ovf = ReadDrain && !w_rd_issue && (r_credits == CredW'(ReadCredits));

  assign InCommandReady   = r_in_rdy;
  assign DRAMCommandValid = r_cmd_valid;
  assign DRAMAddress      = r_addr;
  assign DRAMCommand      = r_cmd;
  assign Error            = r_error;

  // Next-state logic; a write may leave GATE in the same cycle its beat is handed over.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer && w_legal) w_state_nxt = ST_GATE;
        else                      w_state_nxt = ST_IDLE;
      end
      ST_GATE: begin
        if (r_cmd == CmdWrite) begin
          if ((r_wr_ahead != AheadW'(0)) || w_pop) w_state_nxt = ST_ISSUE;
          else                                     w_state_nxt = ST_GATE;
        end else begin
          if (r_credits != CredW'(0)) w_state_nxt = ST_ISSUE;
          else                        w_state_nxt = ST_GATE;
        end
      end
      ST_ISSUE: begin
        if (DRAMCommandReady) w_state_nxt = ST_IDLE;
        else                  w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beats accepted by the MIG ahead of their write commands.
  always_comb begin
    w_wr_ahead_nxt = r_wr_ahead;
    case ({w_pop, w_wr_issue})
      2'b10:   w_wr_ahead_nxt = r_wr_ahead + AheadW'(1);
      2'b01:   w_wr_ahead_nxt = r_wr_ahead - AheadW'(1);
      default: w_wr_ahead_nxt = r_wr_ahead;
    endcase
  end

  // Read credits: drain returns one, read issue consumes one, saturate at full.
  always_comb begin
    w_credits_nxt = r_credits;
    if (ReadDrain && !w_rd_issue) begin
      if (r_credits != CredW'(ReadCredits)) w_credits_nxt = r_credits + CredW'(1);
      else                                  w_credits_nxt = r_credits;
    end else if (w_rd_issue && !ReadDrain) begin
      w_credits_nxt = r_credits - CredW'(1);
    end else begin
      w_credits_nxt = r_credits;
    end
  end

  // FSM state, registered handshake outputs, counters and sticky error.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_in_rdy    <= 1'b1;
      r_wr_ahead  <= AheadW'(0);
      r_credits   <= CredW'(ReadCredits);
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == ST_ISSUE);
      r_in_rdy    <= (w_state_nxt == ST_IDLE);
      r_wr_ahead  <= w_wr_ahead_nxt;
      r_credits   <= w_credits_nxt;
      r_error     <= r_error | (w_in_xfer && !w_legal) | w_credit_ovf;
    end
  end

  // Capture address/command of an accepted legal upstream command.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr <= DDRAWidth'(0);
      r_cmd  <= DDRCWidth'(0);
    end else if (w_in_xfer && w_legal) begin
      r_addr <= InAddress;
      r_cmd  <= InCommand;
    end
  end

  // FIFO pointers; they wrap modulo WDBuffering through the index bits.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= (PtrW+1)'(0);
      r_rd_ptr <= (PtrW+1)'(0);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PtrW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PtrW+1)'(1);
    end
  end

  // FIFO storage write; contents need no reset since pointers qualify them.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr[PtrW-1:0]] <= {InWriteMask, InWriteData};
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: reset state, write gating on data,
// read credit exhaustion, write-ahead limit, illegal commands, mid-issue reset.
module tb_dram_cmd_sequencer;

  logic         Clock;
  logic         Reset_n;
  logic [27:0]  InAddress;
  logic [2:0]   InCommand;
  logic         InCommandValid;
  logic         InCommandReady;
  logic [511:0] InWriteData;
  logic [63:0]  InWriteMask;
  logic         InWriteDataValid;
  logic         InWriteDataReady;
  logic         ReadDrain;
  logic [27:0]  DRAMAddress;
  logic [2:0]   DRAMCommand;
  logic         DRAMCommandValid;
  logic         DRAMCommandReady;
  logic [511:0] DRAMWriteData;
  logic [63:0]  DRAMWriteMask;
  logic         DRAMWriteDataValid;
  logic         DRAMWriteDataReady;
  logic         Error;

  int total = 0;
  int bad   = 0;
  logic [511:0] beats[$];

  dram_cmd_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .InAddress(InAddress), .InCommand(InCommand),
    .InCommandValid(InCommandValid), .InCommandReady(InCommandReady),
    .InWriteData(InWriteData), .InWriteMask(InWriteMask),
    .InWriteDataValid(InWriteDataValid), .InWriteDataReady(InWriteDataReady),
    .ReadDrain(ReadDrain),
    .DRAMAddress(DRAMAddress), .DRAMCommand(DRAMCommand),
    .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
    .DRAMWriteData(DRAMWriteData), .DRAMWriteMask(DRAMWriteMask),
    .DRAMWriteDataValid(DRAMWriteDataValid), .DRAMWriteDataReady(DRAMWriteDataReady),
    .Error(Error)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] beat(input int k);
    logic [31:0] w;
    w = 32'hB000_0000 + 32'(k);
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and log beats the MIG will take.
  task automatic step();
    @(posedge Clock);
    #1;
    if (DRAMWriteDataValid && DRAMWriteDataReady) beats.push_back(DRAMWriteData);
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
    int n;
    n = 0;
    InCommand = c;
    InAddress = a;
    InCommandValid = 1'b1;
    while (!InCommandReady && n < 20) begin
      step();
      n++;
    end
    chk("cmd_accept_timeout", 1'(n < 20), 1'b1);
    step();
    InCommandValid = 1'b0;
  endtask

  task automatic wait_issue(input string tag, input logic [2:0] c, input logic [27:0] a);
    int n;
    n = 0;
    while (!DRAMCommandValid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 1'(n < 20), 1'b1);
    chk({tag, "_cmd"}, DRAMCommand, c);
    chk({tag, "_addr"}, DRAMAddress, a);
    step();
  endtask

  initial begin
    int issued;
    int seen;
    Reset_n = 1'b0;
    InAddress = 28'h0;
    InCommand = 3'b000;
    InCommandValid = 1'b0;
    InWriteData = 512'h0;
    InWriteMask = 64'h0;
    InWriteDataValid = 1'b0;
    ReadDrain = 1'b0;
    DRAMCommandReady = 1'b1;
    DRAMWriteDataReady = 1'b1;
    #12;
    Reset_n = 1'b1;
    step();
    step();

    // 1. reset state
    chk("rst_cmd_valid", DRAMCommandValid, 1'b0);
    chk("rst_wd_valid", DRAMWriteDataValid, 1'b0);
    chk("rst_in_cmd_ready", InCommandReady, 1'b1);
    chk("rst_in_wd_ready", InWriteDataReady, 1'b1);
    chk("rst_error", Error, 1'b0);
    chk("rst_credits", dut.r_credits, 64);

    // 2. write command at T, beat at T+5 -> beat T+6, command T+7
    beats.delete();
    InCommand = 3'b000;
    InAddress = 28'h0123456;
    InCommandValid = 1'b1;
    chk("t2_accept_ready", InCommandReady, 1'b1);
    step();
    InCommandValid = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (DRAMCommandValid) seen = 1;
      step();
    end
    if (DRAMCommandValid) seen = 1;
    chk("t2_no_early_cmd", seen, 0);
    InWriteData = beat(100);
    InWriteMask = 64'h0F0F;
    InWriteDataValid = 1'b1;
    step();
    InWriteDataValid = 1'b0;
    chk("t2_wd_valid_t6", DRAMWriteDataValid, 1'b1);
    chk("t2_wd_data_t6", DRAMWriteData, beat(100));
    chk("t2_wd_mask_t6", DRAMWriteMask, 64'h0F0F);
    chk("t2_cmd_valid_t6", DRAMCommandValid, 1'b0);
    step();
    chk("t2_cmd_valid_t7", DRAMCommandValid, 1'b1);
    chk("t2_cmd_t7", DRAMCommand, 3'b000);
    chk("t2_addr_t7", DRAMAddress, 28'h0123456);
    step();
    chk("t2_cmd_valid_t8", DRAMCommandValid, 1'b0);
    chk("t2_ready_t8", InCommandReady, 1'b1);
    chk("t2_beat_count", beats.size(), 1);

    // 3. 65 reads without drain: 64 issue, 65th waits for a credit
    issued = 0;
    for (int i = 0; i < 64; i++) begin
      send_cmd(3'b001, 28'(i));
      for (int j = 0; j < 10; j++) begin
        if (DRAMCommandValid) begin
          issued++;
          step();
          break;
        end
        step();
      end
    end
    chk("t3_reads_issued", issued, 64);
    send_cmd(3'b001, 28'd64);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (DRAMCommandValid) seen = 1;
      step();
    end
    chk("t3_read65_held", seen, 0);
    chk("t3_credits_empty", dut.r_credits, 0);
    ReadDrain = 1'b1;
    step();
    ReadDrain = 1'b0;
    chk("t3_cmd_valid_d1", DRAMCommandValid, 1'b0);
    step();
    chk("t3_cmd_valid_d2", DRAMCommandValid, 1'b1);
    chk("t3_cmd_d2", DRAMCommand, 3'b001);
    chk("t3_addr_d2", DRAMAddress, 28'd64);
    step();
    chk("t3_credits_after", dut.r_credits, 0);
    ReadDrain = 1'b1;
    repeat (64) step();
    ReadDrain = 1'b0;
    step();
    chk("t3_credits_refill", dut.r_credits, 64);
    chk("t3_no_error", Error, 1'b0);

    // 4. 8 beats without write commands: only 4 reach the MIG
    beats.delete();
    for (int k = 0; k < 8; k++) begin
      InWriteData = beat(k);
      InWriteMask = 64'(k);
      InWriteDataValid = 1'b1;
      step();
    end
    InWriteDataValid = 1'b0;
    repeat (6) step();
    chk("t4_beats_to_mig", beats.size(), 4);
    for (int k = 0; k < 4 && k < beats.size(); k++) chk("t4_beat_order", beats[k], beat(k));
    chk("t4_wd_valid_stalled", DRAMWriteDataValid, 1'b0);
    chk("t4_ready_half", InWriteDataReady, 1'b1);
    for (int k = 8; k < 12; k++) begin
      InWriteData = beat(k);
      InWriteMask = 64'(k);
      InWriteDataValid = 1'b1;
      step();
    end
    InWriteDataValid = 1'b0;
    chk("t4_ready_full", InWriteDataReady, 1'b0);
    beats.delete();
    send_cmd(3'b000, 28'h0ABCDEF);
    wait_issue("t4_wr", 3'b000, 28'h0ABCDEF);
    repeat (4) step();
    chk("t4_one_more_beat", beats.size(), 1);
    if (beats.size() > 0) chk("t4_freed_beat", beats[0], beat(4));
    chk("t4_ready_after_pop", InWriteDataReady, 1'b1);

    // 5. illegal command is dropped and flags Error
    send_cmd(3'b111, 28'h0000BAD);
    chk("t5_error", Error, 1'b1);
    chk("t5_still_idle", InCommandReady, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (DRAMCommandValid) seen = 1;
      step();
    end
    chk("t5_not_forwarded", seen, 0);
    send_cmd(3'b001, 28'h1234567);
    wait_issue("t5_rd", 3'b001, 28'h1234567);
    chk("t5_error_sticky", Error, 1'b1);

    // 6. reset while holding a command in ISSUE
    DRAMCommandReady = 1'b0;
    send_cmd(3'b001, 28'h0FEDCBA);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (DRAMCommandValid) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("t6_in_issue", seen, 1);
    step();
    chk("t6_held", DRAMCommandValid, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_cmd_valid_drop", DRAMCommandValid, 1'b0);
    chk("t6_wd_valid", DRAMWriteDataValid, 1'b0);
    chk("t6_fifo_empty", InWriteDataReady, 1'b1);
    chk("t6_credits", dut.r_credits, 64);
    chk("t6_error_clear", Error, 1'b0);
    DRAMCommandReady = 1'b1;
    #3;
    Reset_n = 1'b1;
    step();
    step();
    chk("t6_no_reissue", DRAMCommandValid, 1'b0);
    chk("t6_idle", InCommandReady, 1'b1);

    // 7. drain with full credits saturates and flags Error
    ReadDrain = 1'b1;
    step();
    ReadDrain = 1'b0;
    step();
    chk("t7_ovf_error", Error, 1'b1);
    chk("t7_credits_sat", dut.r_credits, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
